// File: rtl/core_tile_buf_if.sv
// core_tile_buf_if: fill/drain handshake bundle for the 8x8 tile rotation buffer
interface core_tile_buf_if #(parameter int P_PIX_W = 24);
  logic               I_TB_CLEAR;
  logic [1:0]         I_TB_DEGREES;
  logic               I_TB_DIRECTION;
  logic               I_TB_WR_VALID;
  logic [P_PIX_W-1:0] I_TB_WR_DATA;
  logic               O_TB_WR_READY;
  logic               O_TB_RD_VALID;
  logic [P_PIX_W-1:0] O_TB_RD_DATA;
  logic               I_TB_RD_READY;
  logic               O_TB_BUSY;
  modport slave (
    input  I_TB_CLEAR, I_TB_DEGREES, I_TB_DIRECTION, I_TB_WR_VALID, I_TB_WR_DATA, I_TB_RD_READY,
    output O_TB_WR_READY, O_TB_RD_VALID, O_TB_RD_DATA, O_TB_BUSY
  );
  modport master (
    output I_TB_CLEAR, I_TB_DEGREES, I_TB_DIRECTION, I_TB_WR_VALID, I_TB_WR_DATA, I_TB_RD_READY,
    input  O_TB_WR_READY, O_TB_RD_VALID, O_TB_RD_DATA, O_TB_BUSY
  );
endinterface

// File: rtl/core_tile_buf.sv
// core_tile_buf: ping-pong 8x8 tile buffer that rotates each tile by 0/90/180/270 degrees
// between raster-order fill and raster-order drain.
module core_tile_buf #(parameter int P_PIX_W = 24) (
  input logic            I_TB_HCLK,
  input logic            I_TB_HRESET_N,
  core_tile_buf_if.slave s_tb
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_e;
  bank_e              r_st [2];
  bank_e              w_st_nxt [2];
  logic               r_wr_ptr, r_rd_ptr;
  logic [5:0]         r_wr_cnt, r_rd_cnt;
  logic [1:0]         r_eff [2];
  logic               r_rd_valid;
  logic [P_PIX_W-1:0] r_rd_data;
  logic [P_PIX_W-1:0] r_mem [128];
  logic               w_wr_ready, w_wr_fire, w_adv, w_avail, w_load;
  logic [1:0]         w_eff;
  logic [2:0]         w_r, w_c, w_sr, w_sc;

  assign w_wr_ready = (r_st[r_wr_ptr] == EMPTY) || (r_st[r_wr_ptr] == FILLING);
  assign w_wr_fire  = s_tb.I_TB_WR_VALID && w_wr_ready && !s_tb.I_TB_CLEAR;
  assign w_adv      = !r_rd_valid || s_tb.I_TB_RD_READY;
  assign w_avail    = (r_st[r_rd_ptr] == FULL) || (r_st[r_rd_ptr] == DRAINING);
  assign w_load     = w_adv && w_avail && !s_tb.I_TB_CLEAR;

  // Output position (r',c') maps back to its source pixel; 7-x on 3 bits is ~x.
  always_comb begin
    w_eff = r_eff[r_rd_ptr];
    w_r   = r_rd_cnt[5:3];
    w_c   = r_rd_cnt[2:0];
    w_sr  = (w_eff == 2'd0) ? w_r : (w_eff == 2'd1) ? ~w_c : (w_eff == 2'd2) ? ~w_r : w_c;
    w_sc  = (w_eff == 2'd0) ? w_c : (w_eff == 2'd1) ? w_r : (w_eff == 2'd2) ? ~w_c : ~w_r;
  end

  // Fill and drain never target the same bank: fill needs EMPTY/FILLING, drain FULL/DRAINING.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_st_nxt[b] = r_st[b];
      if (w_wr_fire && r_wr_ptr == 1'(b)) w_st_nxt[b] = (&r_wr_cnt) ? FULL : FILLING;
      if (w_load && r_rd_ptr == 1'(b)) w_st_nxt[b] = (&r_rd_cnt) ? EMPTY : DRAINING;
      if (s_tb.I_TB_CLEAR) w_st_nxt[b] = EMPTY;
    end
  end

  always_ff @(posedge I_TB_HCLK or negedge I_TB_HRESET_N) begin
    if (!I_TB_HRESET_N) begin
      r_st[0] <= EMPTY;
      r_st[1] <= EMPTY;
    end else begin
      r_st[0] <= w_st_nxt[0];
      r_st[1] <= w_st_nxt[1];
    end
  end

  always_ff @(posedge I_TB_HCLK or negedge I_TB_HRESET_N) begin
    if (!I_TB_HRESET_N) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_eff[0]   <= '0;
      r_eff[1]   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (s_tb.I_TB_CLEAR) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
        if (r_wr_cnt == 6'd0) r_eff[r_wr_ptr] <= s_tb.I_TB_DIRECTION ? s_tb.I_TB_DEGREES : 2'd0 - s_tb.I_TB_DEGREES;
        if (&r_wr_cnt) r_wr_ptr <= !r_wr_ptr;
      end
      if (w_load) begin
        r_rd_data <= r_mem[{r_rd_ptr, w_sr, w_sc}];
        r_rd_cnt  <= r_rd_cnt + 6'd1;
        if (&r_rd_cnt) r_rd_ptr <= !r_rd_ptr;
      end
      if (w_adv) r_rd_valid <= w_avail;
    end
  end

  always_ff @(posedge I_TB_HCLK) begin
    if (w_wr_fire) r_mem[{r_wr_ptr, r_wr_cnt}] <= s_tb.I_TB_WR_DATA;
  end

  assign s_tb.O_TB_WR_READY = w_wr_ready;
  assign s_tb.O_TB_RD_VALID = r_rd_valid;
  assign s_tb.O_TB_RD_DATA  = r_rd_data;
  assign s_tb.O_TB_BUSY     = (r_st[0] != EMPTY) || (r_st[1] != EMPTY) || r_rd_valid;
endmodule

// File: tb/tb_core_tile_buf.sv
// tb_core_tile_buf: random tiles against a matrix-rotation reference model with a pixel queue
module tb_core_tile_buf;
  localparam int P = 24;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0, tiles_filled = 0, tiles_drained = 0;
  logic [P-1:0] exp_q [$];

  always #5 clk = ~clk;

  core_tile_buf_if #(.P_PIX_W(P)) tb_if ();
  core_tile_buf #(.P_PIX_W(P)) dut (.I_TB_HCLK(clk), .I_TB_HRESET_N(rst_n), .s_tb(tb_if));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference: rotate the tile as a matrix, a quarter turn at a time, then queue it in raster order.
  task automatic fill_tile(input int n, input bit seq, input logic [1:0] deg, input bit dir);
    logic [P-1:0] src [64];
    logic [P-1:0] m [8][8];
    logic [P-1:0] t [8][8];
    for (int k = 0; k < 64; k++) src[k] = seq ? P'(k) : P'($urandom);
    if (n == 64) begin
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) m[r][c] = src[r*8+c];
      for (int q = 0; q < int'(deg); q++) begin
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) t[r][c] = dir ? m[7-c][r] : m[c][7-r];
        m = t;
      end
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) exp_q.push_back(m[r][c]);
    end
    for (int k = 0; k < n; k++) begin
      int w = 0;
      @(negedge clk);
      tb_if.I_TB_WR_VALID = 1'b1;
      tb_if.I_TB_WR_DATA  = src[k];
      if (k == 0) begin
        tb_if.I_TB_DEGREES   = deg;
        tb_if.I_TB_DIRECTION = dir;
      end else begin
        tb_if.I_TB_DEGREES   = 2'($urandom);
        tb_if.I_TB_DIRECTION = 1'($urandom);
      end
      while (tb_if.O_TB_WR_READY !== 1'b1) begin
        total++;
        if (k != 0 || tiles_filled - tiles_drained < 2) begin
          bad++;
          $display("FAIL wr_ready_stall: got ready=%b at pixel %0d with %0d tiles held, required 1", tb_if.O_TB_WR_READY, k, tiles_filled - tiles_drained);
        end
        if (++w > 3000) begin
          bad++;
          $display("FAIL fill_timeout: got no ready at pixel %0d, required acceptance within 3000 cycles", k);
          tb_if.I_TB_WR_VALID = 1'b0;
          return;
        end
        @(negedge clk);
      end
      @(posedge clk);
      #1;
    end
    tb_if.I_TB_WR_VALID = 1'b0;
    if (n == 64) tiles_filled++;
  endtask

  task automatic drain(input int n, input bit rnd, input bit contig, input int lat);
    int got = 0, cyc = 0;
    bit seen = 1'b0, holding = 1'b0;
    logic [P-1:0] hold = '0, e;
    while (got < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (holding) begin
        total++;
        if (tb_if.O_TB_RD_VALID !== 1'b1 || tb_if.O_TB_RD_DATA !== hold) begin
          bad++;
          $display("FAIL hold_stable: got valid=%b data=%h, required valid=1 data=%h", tb_if.O_TB_RD_VALID, tb_if.O_TB_RD_DATA, hold);
        end
        holding = 1'b0;
      end
      if (contig && seen) begin
        total++;
        if (tb_if.O_TB_RD_VALID !== 1'b1) begin
          bad++;
          $display("FAIL throughput: got valid=%b after %0d pixels, required 1", tb_if.O_TB_RD_VALID, got);
        end
      end
      tb_if.I_TB_RD_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tb_if.O_TB_RD_VALID === 1'b1) begin
        if (!seen && lat > 0) begin
          total++;
          if (cyc != lat) begin
            bad++;
            $display("FAIL latency: got first valid at cycle %0d, required %0d", cyc, lat);
          end
        end
        seen = 1'b1;
        if (tb_if.I_TB_RD_READY) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_pixel: got data=%h, required no pixel", tb_if.O_TB_RD_DATA);
          end else begin
            e = exp_q.pop_front();
            if (tb_if.O_TB_RD_DATA !== e) begin
              bad++;
              $display("FAIL pixel[%0d]: got %h, required %h", got, tb_if.O_TB_RD_DATA, e);
            end
          end
          got++;
          if (got % 64 == 0) tiles_drained++;
        end else begin
          hold = tb_if.O_TB_RD_DATA;
          holding = 1'b1;
        end
      end
    end
    if (got < n) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pixels, required %0d", got, n);
    end
    @(posedge clk);
    #1;
    tb_if.I_TB_RD_READY = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (tb_if.O_TB_BUSY !== 1'b0 || tb_if.O_TB_RD_VALID !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: got busy=%b valid=%b, required 0 0", tag, tb_if.O_TB_BUSY, tb_if.O_TB_RD_VALID);
    end
  endtask

  task automatic test_reset();
    tb_if.I_TB_CLEAR = 1'b0;
    tb_if.I_TB_DEGREES = 2'd0;
    tb_if.I_TB_DIRECTION = 1'b1;
    tb_if.I_TB_WR_VALID = 1'b0;
    tb_if.I_TB_WR_DATA = '0;
    tb_if.I_TB_RD_READY = 1'b0;
    #1;
    total++;
    if (tb_if.O_TB_RD_VALID !== 1'b0 || tb_if.O_TB_RD_DATA !== '0 || tb_if.O_TB_BUSY !== 1'b0 || tb_if.O_TB_WR_READY !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got valid=%b data=%h busy=%b ready=%b, required 0 0 0 1", tb_if.O_TB_RD_VALID, tb_if.O_TB_RD_DATA, tb_if.O_TB_BUSY, tb_if.O_TB_WR_READY);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (tb_if.O_TB_RD_VALID !== 1'b0 || tb_if.O_TB_WR_READY !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: got valid=%b ready=%b, required 0 1", tb_if.O_TB_RD_VALID, tb_if.O_TB_WR_READY);
    end
  endtask

  task automatic test_rotations();
    logic [1:0] degs [8] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0};
    bit dirs [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      tiles_filled = 0;
      tiles_drained = 0;
      tb_if.I_TB_RD_READY = 1'b1;
      fill_tile(64, 1'b1, degs[i], dirs[i]);
      drain(64, 1'b0, 1'b1, 2);
      check_idle("rotation");
    end
  endtask

  task automatic test_back_to_back();
    for (int pass = 0; pass < 2; pass++) begin
      tiles_filled = 0;
      tiles_drained = 0;
      fork
        for (int t = 0; t < 3; t++) fill_tile(64, 1'b0, 2'($urandom), 1'($urandom));
        drain(192, pass == 1, pass == 0, -1);
      join
      check_idle("back_to_back");
    end
  endtask

  task automatic test_clear();
    tiles_filled = 0;
    tiles_drained = 0;
    tb_if.I_TB_RD_READY = 1'b0;
    fill_tile(64, 1'b0, 2'd1, 1'b1);
    fill_tile(30, 1'b0, 2'd2, 1'b1);
    @(negedge clk);
    total++;
    if (tb_if.O_TB_BUSY !== 1'b1) begin
      bad++;
      $display("FAIL busy_before_clear: got %b, required 1", tb_if.O_TB_BUSY);
    end
    tb_if.I_TB_WR_VALID = 1'b1;
    tb_if.I_TB_WR_DATA = P'($urandom);
    tb_if.I_TB_CLEAR = 1'b1;
    @(posedge clk);
    #1;
    tb_if.I_TB_CLEAR = 1'b0;
    tb_if.I_TB_WR_VALID = 1'b0;
    @(negedge clk);
    check_idle("clear");
    total++;
    if (tb_if.O_TB_WR_READY !== 1'b1) begin
      bad++;
      $display("FAIL clear_ready: got %b, required 1", tb_if.O_TB_WR_READY);
    end
    exp_q.delete();
    tiles_filled = 0;
    tiles_drained = 0;
    tb_if.I_TB_RD_READY = 1'b1;
    fill_tile(64, 1'b0, 2'd3, 1'b1);
    drain(64, 1'b0, 1'b1, 2);
    check_idle("after_clear");
  endtask

  task automatic test_async_reset();
    tiles_filled = 0;
    tiles_drained = 0;
    tb_if.I_TB_RD_READY = 1'b0;
    fill_tile(64, 1'b0, 2'd3, 1'b0);
    fill_tile(10, 1'b0, 2'd1, 1'b1);
    drain(20, 1'b1, 1'b0, -1);
    total++;
    if (tb_if.O_TB_RD_VALID !== 1'b1) begin
      bad++;
      $display("FAIL mid_drain_valid: got %b, required 1", tb_if.O_TB_RD_VALID);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (tb_if.O_TB_RD_VALID !== 1'b0 || tb_if.O_TB_RD_DATA !== '0 || tb_if.O_TB_BUSY !== 1'b0 || tb_if.O_TB_WR_READY !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got valid=%b data=%h busy=%b ready=%b, required 0 0 0 1", tb_if.O_TB_RD_VALID, tb_if.O_TB_RD_DATA, tb_if.O_TB_BUSY, tb_if.O_TB_WR_READY);
    end
    exp_q.delete();
    tiles_filled = 0;
    tiles_drained = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tb_if.I_TB_RD_READY = 1'b1;
    repeat (10) begin
      @(negedge clk);
      total++;
      if (tb_if.O_TB_RD_VALID !== 1'b0) begin
        bad++;
        $display("FAIL stale_pixel: got valid=%b data=%h, required valid=0", tb_if.O_TB_RD_VALID, tb_if.O_TB_RD_DATA);
      end
    end
    fill_tile(64, 1'b0, 2'd2, 1'b0);
    drain(64, 1'b1, 1'b0, -1);
    check_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_rotations();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_tile_buf.md
CORE_TILE_BUF -- requirements
Module: core_tile_buf

Interface
REQ-001 The block SHALL have parameter P_PIX_W, default 24, giving the pixel width in bits (RGB888).
REQ-002 The block SHALL have port I_TB_HCLK, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port I_TB_HRESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port I_TB_CLEAR, input, 1 bit: synchronous flush.
REQ-005 The block SHALL have port I_TB_DEGREES, input, 2 bits: 0=0°, 1=90°, 2=180°, 3=270°.
REQ-006 The block SHALL have port I_TB_DIRECTION, input, 1 bit: 1=clockwise, 0=counter-clockwise.
REQ-007 The block SHALL have port I_TB_WR_VALID, input, 1 bit: a fill pixel is offered.
REQ-008 The block SHALL have port I_TB_WR_DATA, input, P_PIX_W bits: the fill pixel, in raster order within the 8x8 tile.
REQ-009 The block SHALL have port O_TB_WR_READY, output, 1 bit: the block can accept a fill pixel.
REQ-010 The block SHALL have port O_TB_RD_VALID, output, 1 bit: a rotated pixel is presented.
REQ-011 The block SHALL have port O_TB_RD_DATA, output, P_PIX_W bits: the rotated pixel, in output raster order.
REQ-012 The block SHALL have port I_TB_RD_READY, input, 1 bit: the downstream side accepts a pixel.
REQ-013 The block SHALL have port O_TB_BUSY, output, 1 bit: any bank is non-empty or O_TB_RD_VALID is high.

Function
REQ-014 The block SHALL hold two 64-pixel tile banks (ping-pong); each bank SHALL have state EMPTY, FILLING, FULL or DRAINING.
REQ-015 A fill transfer SHALL occur on any edge where I_TB_WR_VALID and O_TB_WR_READY are both high.
REQ-016 O_TB_WR_READY SHALL be high whenever the fill-pointer bank is EMPTY or FILLING.
REQ-017 The fill counter SHALL be 6 bits; the pixel with index k (row=k[5:3], col=k[2:0]) SHALL be stored at that location.
REQ-018 When the first pixel of a tile is accepted, the effective clockwise angle eff = DIRECTION ? DEGREES : (4-DEGREES) mod 4 SHALL be latched with that bank.
REQ-019 DEGREES and DIRECTION changes made mid-tile SHALL NOT affect that tile.
REQ-020 On acceptance of pixel 63, the bank SHALL become FULL, the fill pointer SHALL toggle, and the fill counter SHALL wrap to 0.
REQ-021 Drain order SHALL be output raster order (r',c'), r' major, each 0..7; the source pixel for each position SHALL be:
  - eff 0: (r',c')
  - eff 1: (7-c',r')
  - eff 2: (7-r',7-c')
  - eff 3: (c',7-r')
REQ-022 O_TB_RD_DATA and O_TB_RD_VALID SHALL be registered.
REQ-023 The output register SHALL load the next drain pixel on any edge where (!O_TB_RD_VALID || I_TB_RD_READY) holds and the drain-pointer bank is FULL or DRAINING with pixels remaining.
REQ-024 If the condition in REQ-023 holds with no pixel remaining, O_TB_RD_VALID SHALL go low.
REQ-025 While O_TB_RD_VALID=1 and I_TB_RD_READY=0, O_TB_RD_DATA and O_TB_RD_VALID SHALL hold stable.
REQ-026 Latency: if the edge accepting pixel 63 is edge N and the output is idle, O_TB_RD_VALID SHALL be high after edge N+1, carrying output pixel 0.
REQ-027 With I_TB_RD_READY held high, throughput SHALL be 1 pixel/cycle, including across bank boundaries with no bubble.
REQ-028 When output pixel 63 is loaded into the output register, the bank SHALL return to EMPTY and the drain pointer SHALL toggle.
REQ-029 Filling one bank and draining the other on the same edge SHALL both proceed.
REQ-030 A bank that becomes EMPTY on an edge SHALL be writable (O_TB_WR_READY=1) from the next cycle.
REQ-031 I_TB_CLEAR=1 SHALL, on the next edge, return:
  - both banks to EMPTY
  - both pointers and counters to 0
  - O_TB_RD_VALID to 0
REQ-032 I_TB_CLEAR SHALL take priority over a simultaneous fill or drain transfer, and the pixel offered on that edge SHALL be discarded.

Reset
REQ-033 On I_TB_HRESET_N=0, immediately and independent of the clock, the block SHALL set:
  - both banks EMPTY
  - pointers, counters and latched angles 0
  - O_TB_RD_VALID=0, O_TB_RD_DATA=0, O_TB_BUSY=0
  - O_TB_WR_READY=1
REQ-034 Bank memory contents SHALL need no reset.
REQ-035 Reset asserted mid-operation SHALL abandon any partial tile, and no pixel SHALL appear on the output after release until a new complete tile is filled.

Verification
REQ-036 Fill pixels 0..63 with DEGREES=0, DIRECTION=1, RD_READY=1 -> output 0,1,2,...,63, with RD_VALID high from the edge after pixel 63 is accepted.
REQ-037 Same data, DEGREES=1, DIRECTION=1 -> output begins 56,48,40,...,0,57,49; final pixel is 7.
REQ-038 Same data, DEGREES=1, DIRECTION=0 -> output begins 7,15,23,...,63,6,14; this SHALL equal DEGREES=3, DIRECTION=1; DEGREES=2 -> output is 63 down to 0.
REQ-039 Stream 3 tiles back-to-back with RD_READY random 50% -> no pixel loss or duplication, and WR_READY=0 only while both banks are occupied.
REQ-040 Assert CLEAR on the same edge as fill pixel 30 -> the next edge has RD_VALID=0 and BUSY=0, and a new 64-pixel tile then drains intact.
REQ-041 Assert HRESET_N low mid-drain at pixel 20 -> outputs reach reset values without a clock edge, and no stale pixel appears after release.
